// File: rtl/jk_ubus_slave_mem.sv
// Byte-wide UBUS memory slave: decodes a BASE_ADDR window, inserts WAIT_CYCLES
// wait states before every data beat and flags beats that fall outside the window.
module jk_ubus_slave_mem #(
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter int          MEM_DEPTH   = 256,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [1:0]  size,
   input  logic        read,
   input  logic        write,
   input  logic        bip,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        wait_state,
   output logic        error
);

   localparam int         AW        = $clog2(MEM_DEPTH);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

   state_t        state;
   logic [15:0]   ptr;
   logic [3:0]    beats_left;
   logic [3:0]    wcnt;
   logic          is_read;

   logic [7:0]    mem [MEM_DEPTH];
   logic          ptr_ok;
   logic [AW-1:0] ptr_idx;
   logic          mem_we;

   // A 17-bit difference keeps addresses below BASE_ADDR from aliasing into the window.
   function automatic logic in_window(input logic [15:0] a);
      logic [16:0] diff;
      diff = {1'b0, a} - {1'b0, BASE_ADDR};
      return !diff[16] && (diff[15:0] < 16'(MEM_DEPTH));
   endfunction

   assign ptr_ok  = in_window(ptr);
   assign ptr_idx = AW'(ptr - BASE_ADDR);
   assign mem_we  = (state == XFER) && !is_read && ptr_ok;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= 16'd0;
         beats_left <= 4'd0;
         wcnt       <= 4'd0;
         is_read    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if ((read ^ write) && in_window(addr)) begin
                  ptr        <= addr;
                  is_read    <= read;
                  beats_left <= 4'd1 << size;
                  wcnt       <= WAIT_LOAD;
                  state      <= (WAIT_CYCLES == 0) ? XFER : WAIT;
               end
            end
            WAIT: begin
               if (wcnt == 4'd0) state <= XFER;
               else              wcnt  <= wcnt - 4'd1;
            end
            XFER: begin
               ptr        <= ptr + 16'd1;
               beats_left <= beats_left - 4'd1;
               if (beats_left == 4'd1 || !bip) begin
                  state <= IDLE;
               end else begin
                  wcnt  <= WAIT_LOAD;
                  state <= (WAIT_CYCLES == 0) ? XFER : WAIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: storage has no reset branch; it must keep its contents across reset
   // and stays a plain RAM without a per-bit clear path.
   always_ff @(posedge clk) begin
      if (mem_we) mem[ptr_idx] <= data_in;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wait_state = 1'b0;
      data_oe    = 1'b0;
      error      = 1'b0;
      data_out   = 8'h00;
      if (state == WAIT) begin
         wait_state = 1'b1;
      end else if (state == XFER) begin
         error   = !ptr_ok;
         data_oe = is_read;
         if (is_read && ptr_ok) data_out = mem[ptr_idx];
      end
   end

endmodule

// File: tb/tb_jk_ubus_slave_mem.sv
// Directed bench for jk_ubus_slave_mem with default parameters
// (BASE_ADDR=0, MEM_DEPTH=256, WAIT_CYCLES=1).
module tb_jk_ubus_slave_mem;

   logic        clk;
   logic        reset;
   logic [15:0] addr;
   logic [1:0]  size;
   logic        read;
   logic        write;
   logic        bip;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        data_oe;
   logic        wait_state;
   logic        error;

   int total = 0;
   int bad   = 0;

   logic [7:0] wd      [8];
   logic [7:0] rd_exp  [8];
   logic       err_exp [8];

   jk_ubus_slave_mem dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .size       (size),
      .read       (read),
      .write      (write),
      .bip        (bip),
      .data_in    (data_in),
      .data_out   (data_out),
      .data_oe    (data_oe),
      .wait_state (wait_state),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic addr_phase(input logic r, input logic w, input logic [15:0] a, input logic [1:0] s);
      read  = r;
      write = w;
      addr  = a;
      size  = s;
      tick();
      read  = 1'b0;
      write = 1'b0;
      addr  = 16'h0000;
   endtask

   // Writes wd[0..n-1]; bip drops on beat n, which ends the burst early when n < 1<<s.
   task automatic write_burst(input logic [15:0] a, input logic [1:0] s, input int n);
      bip = 1'b1;
      addr_phase(1'b0, 1'b1, a, s);
      for (int i = 0; i < n; i++) begin
         check("wr_wait", 16'(wait_state), 16'd1);
         data_in = wd[i];
         if (i == n - 1) bip = 1'b0;
         tick();
         check("wr_xfer_err", 16'(error), 16'd0);
         check("wr_xfer_wait", 16'(wait_state), 16'd0);
         tick();
      end
      bip = 1'b1;
   endtask

   // Reads n beats holding bip high throughout, then expects IDLE.
   task automatic read_burst(input logic [15:0] a, input logic [1:0] s, input int n);
      bip = 1'b1;
      addr_phase(1'b1, 1'b0, a, s);
      for (int i = 0; i < n; i++) begin
         check("rd_wait", 16'(wait_state), 16'd1);
         check("rd_wait_oe", 16'(data_oe), 16'd0);
         check("rd_wait_data", 16'(data_out), 16'd0);
         tick();
         check("rd_data", 16'(data_out), 16'(rd_exp[i]));
         check("rd_err", 16'(error), 16'(err_exp[i]));
         check("rd_oe", 16'(data_oe), 16'd1);
         tick();
      end
      check("rd_idle_wait", 16'(wait_state), 16'd0);
      check("rd_idle_oe", 16'(data_oe), 16'd0);
   endtask

   initial begin
      reset   = 1'b1;
      addr    = 16'h0000;
      size    = 2'b00;
      read    = 1'b0;
      write   = 1'b0;
      bip     = 1'b1;
      data_in = 8'h00;
      for (int i = 0; i < 8; i++) err_exp[i] = 1'b0;
      #1;
      check("rst_wait", 16'(wait_state), 16'd0);
      check("rst_err", 16'(error), 16'd0);
      check("rst_oe", 16'(data_oe), 16'd0);
      check("rst_data", 16'(data_out), 16'd0);
      tick();
      tick();
      reset = 1'b0;

      // Single write of A5 at 0010, accepted on the first edge after reset.
      data_in = 8'hA5;
      addr_phase(1'b0, 1'b1, 16'h0010, 2'b00);
      check("w1_wait", 16'(wait_state), 16'd1);
      check("w1_wait_oe", 16'(data_oe), 16'd0);
      tick();
      check("w1_xfer_wait", 16'(wait_state), 16'd0);
      check("w1_xfer_err", 16'(error), 16'd0);
      check("w1_xfer_oe", 16'(data_oe), 16'd0);
      tick();
      // Back-to-back read of the same byte.
      rd_exp[0] = 8'hA5;
      read_burst(16'h0010, 2'b00, 1);

      // Four-beat write then read at 0020.
      wd[0] = 8'h01; wd[1] = 8'h02; wd[2] = 8'h03; wd[3] = 8'h04;
      write_burst(16'h0020, 2'b10, 4);
      rd_exp[0] = 8'h01; rd_exp[1] = 8'h02; rd_exp[2] = 8'h03; rd_exp[3] = 8'h04;
      read_burst(16'h0020, 2'b10, 4);

      // Burst crossing the top of the window.
      wd[0] = 8'h11; wd[1] = 8'h22;
      write_burst(16'h00FE, 2'b01, 2);
      rd_exp[0] = 8'h11; rd_exp[1] = 8'h22; rd_exp[2] = 8'h00; rd_exp[3] = 8'h00;
      err_exp[2] = 1'b1; err_exp[3] = 1'b1;
      read_burst(16'h00FE, 2'b10, 4);
      err_exp[2] = 1'b0; err_exp[3] = 1'b0;

      // Eight-beat write terminated by bip=0 on beat 3.
      wd[0] = 8'h5A;
      write_burst(16'h0043, 2'b00, 1);
      wd[0] = 8'hB1; wd[1] = 8'hB2; wd[2] = 8'hB3;
      write_burst(16'h0040, 2'b11, 3);
      check("early_idle_wait", 16'(wait_state), 16'd0);
      check("early_idle_err", 16'(error), 16'd0);
      tick();
      check("early_still_idle", 16'(wait_state), 16'd0);
      rd_exp[0] = 8'hB1; rd_exp[1] = 8'hB2; rd_exp[2] = 8'hB3; rd_exp[3] = 8'h5A;
      read_burst(16'h0040, 2'b10, 4);

      // Rejected address phases.
      addr_phase(1'b1, 1'b1, 16'h0010, 2'b00);
      check("both_wait", 16'(wait_state), 16'd0);
      check("both_oe", 16'(data_oe), 16'd0);
      tick();
      check("both_later_oe", 16'(data_oe), 16'd0);
      check("both_later_err", 16'(error), 16'd0);
      addr_phase(1'b1, 1'b0, 16'h0400, 2'b00);
      check("oow_wait", 16'(wait_state), 16'd0);
      tick();
      check("oow_later_oe", 16'(data_oe), 16'd0);
      check("oow_later_err", 16'(error), 16'd0);

      // Reset during beat 2 of a four-beat write.
      wd[0] = 8'hC0; wd[1] = 8'hC1;
      write_burst(16'h0060, 2'b01, 2);
      bip = 1'b1;
      addr_phase(1'b0, 1'b1, 16'h0060, 2'b10);
      data_in = 8'hD0;
      tick();
      tick();
      check("abort_wait2", 16'(wait_state), 16'd1);
      data_in = 8'hD1;
      tick();
      check("abort_xfer2", 16'(wait_state), 16'd0);
      #1 reset = 1'b1;
      #1;
      check("abort_rst_wait", 16'(wait_state), 16'd0);
      check("abort_rst_err", 16'(error), 16'd0);
      check("abort_rst_oe", 16'(data_oe), 16'd0);
      check("abort_rst_data", 16'(data_out), 16'd0);
      tick();
      reset = 1'b0;
      rd_exp[0] = 8'hD0; rd_exp[1] = 8'hC1;
      read_burst(16'h0060, 2'b01, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
